// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants for the multicycle MIPS controller: opcodes,
//               R-type function codes, FSM state encodings, ALUOp and ALUCtl
//               codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  // Instruction opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // FSM state encodings (4 bits, exported on the debug port)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  // ALUOp codes from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  // ALUCtl codes driven to the ALU
  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// Module      : alu_decoder
// Description : Combinational ALU control decode from ALUOp and Funct.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl
);

  // Fixed operations for address/branch math, funct-driven for R-type
  always_comb begin
    alu_ctl = ALUCTL_AND;
    case (alu_op)
      ALUOP_ADD: alu_ctl = ALUCTL_ADD;
      ALUOP_SUB: alu_ctl = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_ctl = ALUCTL_ADD;
          FUNCT_SUB: alu_ctl = ALUCTL_SUB;
          FUNCT_AND: alu_ctl = ALUCTL_AND;
          FUNCT_OR:  alu_ctl = ALUCTL_OR;
          FUNCT_SLT: alu_ctl = ALUCTL_SLT;
          default:   alu_ctl = ALUCTL_AND;
        endcase
      end
      default:   alu_ctl = ALUCTL_AND;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle MIPS control FSM (LW, SW, R-type, BEQ, ADDI, J)
//               with memory handshake stalls and an ALU control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OPCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUCtl,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] state_next;
  logic [1:0] alu_op;

  // Raw decodes of the strobes; these are gated by reset before leaving
  logic pc_write_raw;
  logic branch_raw;
  logic ir_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;
  logic illegal_raw;

  // State register; asynchronous reset returns to FETCH immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state control decode; everything defaults to 0
  always_comb begin
    state_next    = S_FETCH;
    alu_op        = ALUOP_ADD;
    pc_write_raw  = 1'b0;
    branch_raw    = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    IorD          = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSrc         = 2'b00;

    case (state)
      S_FETCH: begin
        // PC+4 is computed every cycle; the load only commits when memory
        // delivers the instruction, so the strobes follow mem_ready.
        ALUSrcB      = 2'b01;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        state_next   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target speculatively computed into ALUOut
        ALUSrcB = 2'b11;
        case (OPCode)
          OP_RTYPE: state_next = S_EXECUTE;
          OP_LW,
          OP_SW:    state_next = S_MEMADR;
          OP_BEQ:   state_next = S_BRANCH;
          OP_ADDI:  state_next = S_ADDIEX;
          OP_J:     state_next = S_JUMP;
          default: begin
            illegal_raw = 1'b1;
            state_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (OPCode == OP_LW) begin
          state_next = S_MEMRD;
        end else if (OPCode == OP_SW) begin
          state_next = S_MEMWR;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_MEMRD: begin
        IorD       = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_MEMWR: begin
        // Write strobe held until memory accepts it
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
        state_next    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b00;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        alu_op     = ALUOP_SUB;
        PCSrc      = 2'b01;
        branch_raw = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
      end
      S_JUMP: begin
        PCSrc        = 2'b10;
        pc_write_raw = 1'b1;
        state_next   = S_FETCH;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Strobes are masked by reset so they drop without waiting for a clock,
  // including the Mealy FETCH strobes that would otherwise follow mem_ready.
  assign PCWrite    = rst_n & pc_write_raw;
  assign Branch     = rst_n & branch_raw;
  assign IRWrite    = rst_n & ir_write_raw;
  assign MemWrite   = rst_n & mem_write_raw;
  assign RegWrite   = rst_n & reg_write_raw;
  assign illegal_op = rst_n & illegal_raw;

  alu_decoder u_alu_decoder (
    .alu_op  (alu_op),
    .funct   (Funct),
    .alu_ctl (ALUCtl)
  );

endmodule

`default_nettype wire
